fp_addsub_sched: RTL and testbench

Controller that shares one single-precision floating-point add/subtract engine among N requesters. It arbitrates round-robin, and it implements subtraction by flipping the sign bit of operand B before issue. It drives the engine's enable/done handshake, returns each result tagged with the requester index, and aborts an operation if the engine does not respond in time. It sits between the custom-instruction front ends and the shared engine instance.

---
 rtl/fp_ctrl_pkg.sv | 17 +
 rtl/fp_addsub_sched_if.sv | 27 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/fp_addsub_sched.sv | 129 ++++++++++++
 tb/tb_fp_addsub_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared types and helpers for the FP add/sub scheduler.
// Holds the word width, FSM state type and sign-flip helper.
package fp_ctrl_pkg;
  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [FP_W-1:0] fp_negate(
    input logic [FP_W-1:0] x
  );
    return {~x[FP_W-1], x[FP_W-2:0]};
  endfunction
endpackage

// File: rtl/fp_addsub_sched_if.sv
// Requester-side bundle: packed requests/operands in, tagged
// responses out. master = front ends, slave = scheduler.
interface fp_addsub_sched_if #(
  parameter int N = 4
);
  import fp_ctrl_pkg::*;
  localparam int IW = $clog2(N);

  logic [N-1:0]      req;
  logic [N-1:0]      op_sub;
  logic [FP_W*N-1:0] a_in;
  logic [FP_W*N-1:0] b_in;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [FP_W-1:0]   resp_data;
  logic              resp_err;

  modport master (
    output req, op_sub, a_in, b_in,
    input  resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req, op_sub, a_in, b_in,
    output resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past
// i_ptr. Ports: i_req, i_ptr in; o_grant (one-hot), o_idx out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic          w_hit;
  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_hit   = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!w_hit && i_req[w_j]) begin
        w_hit      = 1'b1;
        o_idx      = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one FP add/sub engine among N requesters.
// Ports: clk, reset, bus (requesters), eng_* (engine), busy.
module fp_addsub_sched
  import fp_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  fp_addsub_sched_if.slave  bus,
  output logic              eng_enable,
  output logic [FP_W-1:0]   eng_dataa,
  output logic [FP_W-1:0]   eng_datab,
  input  logic              eng_done,
  input  logic [FP_W-1:0]   eng_result,
  output logic              busy
);
  localparam int IW = $clog2(N);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [7:0]      r_cnt;
  logic            r_en;
  logic [FP_W-1:0] r_da;
  logic [FP_W-1:0] r_db;
  logic            r_rv;
  logic            r_rerr;
  logic [IW-1:0]   r_rid;
  logic [FP_W-1:0] r_rdata;

  logic [N-1:0]    w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_issue;
  logic            w_sub;
  logic [FP_W-1:0] w_a;
  logic [FP_W-1:0] w_b;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any = |bus.req;
  assign w_sub = |(bus.op_sub & w_grant);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) begin
        w_a = bus.a_in[k*FP_W +: FP_W];
        w_b = bus.b_in[k*FP_W +: FP_W];
      end
    end
  end

  // DRAIN may only issue once the engine has dropped done
  assign w_issue = w_any &&
    ((r_state == IDLE) ||
     (r_state == DRAIN && !eng_done));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DRAIN;
      r_ptr   <= IW'(N - 1);
      r_id    <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_da    <= '0;
      r_db    <= '0;
      r_rv    <= 1'b0;
      r_rerr  <= 1'b0;
      r_rid   <= '0;
      r_rdata <= '0;
    end else begin
      r_rv <= 1'b0;
      if (w_issue) begin
        r_da    <= w_a;
        r_db    <= w_sub ? fp_negate(w_b) : w_b;
        r_en    <= 1'b1;
        r_id    <= w_idx;
        r_ptr   <= w_idx;
        r_cnt   <= '0;
        r_state <= BUSY;
      end else begin
        unique case (r_state)
          IDLE: r_state <= IDLE;
          BUSY: begin
            if (eng_done) begin
              r_rv    <= 1'b1;
              r_rerr  <= 1'b0;
              r_rid   <= r_id;
              r_rdata <= eng_result;
              r_en    <= 1'b0;
              r_state <= DRAIN;
            end else if (r_cnt == 8'(TIMEOUT - 1)) begin
              r_rv    <= 1'b1;
              r_rerr  <= 1'b1;
              r_rid   <= r_id;
              r_rdata <= '0;
              r_en    <= 1'b0;
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          DRAIN: begin
            if (!eng_done) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign eng_enable     = r_en;
  assign eng_dataa      = r_da;
  assign eng_datab      = r_db;
  assign busy           = (r_state != IDLE);
  assign bus.resp_valid = r_rv;
  assign bus.resp_err   = r_rerr;
  assign bus.resp_id    = r_rid;
  assign bus.resp_data  = r_rdata;
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched with a registered
// engine model and a batch-level round-robin reference.
module tb_fp_addsub_sched;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_addsub_sched_if #(.N(N)) bus();

  logic        eng_enable, eng_done, busy;
  logic [31:0] eng_dataa, eng_datab, eng_result;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic        hold_off, force_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          rq_id[$];
  int          rq_cyc[$];
  logic [31:0] rq_data[$];
  logic        rq_err[$];

  logic [31:0] op_a[N];
  logic [31:0] op_b[N];
  logic        op_s[N];
  int          ref_ptr;

  fp_addsub_sched #(.N(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .eng_enable (eng_enable),
    .eng_dataa  (eng_dataa),
    .eng_datab  (eng_datab),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(
    input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] expect_res(input int i);
    logic [31:0] b;
    b = op_b[i];
    if (op_s[i]) b[31] = ~b[31];
    return fadd(op_a[i], b);
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)),
            23'($urandom)};
  endfunction

  assign eng_done   = m_done | force_done;
  assign eng_result = m_res;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hold_off) m_done <= 1'b0;
    else          m_done <= eng_enable;
    if (eng_enable) m_res <= fadd(eng_dataa, eng_datab);
  end

  task automatic load(input int i);
    bus.a_in[i*32 +: 32] = op_a[i];
    bus.b_in[i*32 +: 32] = op_b[i];
    bus.op_sub[i]        = op_s[i];
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.resp_valid) begin
      rq_id.push_back(int'(bus.resp_id));
      rq_cyc.push_back(cyc);
      rq_data.push_back(bus.resp_data);
      rq_err.push_back(bus.resp_err);
      bus.req[bus.resp_id] = 1'b0;
    end
  endtask

  task automatic clear_q();
    rq_id.delete(); rq_cyc.delete();
    rq_data.delete(); rq_err.delete();
  endtask

  task automatic wait_resp(input int n, input int bound);
    for (int k = 0; k < bound && rq_id.size() < n; k++) step();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && busy; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    ref_ptr = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tests += 8;
    if (eng_enable !== 1'b0) begin fails++;
      $display("FAIL rst_en got %b want 0", eng_enable); end
    if (eng_dataa !== 32'd0) begin fails++;
      $display("FAIL rst_da got %h want 0", eng_dataa); end
    if (eng_datab !== 32'd0) begin fails++;
      $display("FAIL rst_db got %h want 0", eng_datab); end
    if (bus.resp_valid !== 1'b0) begin fails++;
      $display("FAIL rst_rv got %b want 0", bus.resp_valid); end
    if (bus.resp_err !== 1'b0) begin fails++;
      $display("FAIL rst_err got %b want 0", bus.resp_err); end
    if (bus.resp_id !== 2'd0) begin fails++;
      $display("FAIL rst_id got %0d want 0", bus.resp_id); end
    if (bus.resp_data !== 32'd0) begin fails++;
      $display("FAIL rst_data got %h want 0", bus.resp_data); end
    if (busy !== 1'b1) begin fails++;
      $display("FAIL rst_busy got %b want 1", busy); end
    reset = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin fails++;
      $display("FAIL rst_idle busy got %b want 0", busy); end
    ref_ptr = N - 1;
  endtask

  task automatic test_single_add();
    int t0;
    clear_q();
    op_a[2] = 32'h3F800000; op_b[2] = 32'h40000000;
    op_s[2] = 1'b0;
    load(2);
    bus.req[2] = 1'b1;
    t0 = cyc;
    wait_resp(1, 20);
    tests++;
    if (rq_id.size() != 1) begin fails++;
      $display("FAIL add_cnt got %0d want 1", rq_id.size());
    end else begin
      tests += 4;
      if (rq_id[0] != 2) begin fails++;
        $display("FAIL add_id got %0d want 2", rq_id[0]); end
      if (rq_data[0] !== 32'h40400000) begin fails++;
        $display("FAIL add_data got %h want 40400000",
                 rq_data[0]); end
      if (rq_err[0] !== 1'b0) begin fails++;
        $display("FAIL add_err got %b want 0", rq_err[0]); end
      if (rq_cyc[0] - t0 != 3) begin fails++;
        $display("FAIL add_lat got %0d want 3",
                 rq_cyc[0] - t0); end
    end
    for (int k = 0; k < 6; k++) step();
    tests++;
    if (rq_id.size() != 1) begin fails++;
      $display("FAIL add_once got %0d want 1", rq_id.size());
    end
    wait_idle();
  endtask

  task automatic test_subtract();
    logic [31:0] ta[3], tb[3], tdb[3];
    ta[0] = 32'h40400000; tb[0] = 32'h3F800000;
    tdb[0] = 32'hBF800000;
    ta[1] = 32'h3F800000; tb[1] = 32'h00000000;
    tdb[1] = 32'h80000000;
    ta[2] = 32'h3F800000; tb[2] = 32'h80000000;
    tdb[2] = 32'h00000000;
    for (int t = 0; t < 3; t++) begin
      clear_q();
      op_a[0] = ta[t]; op_b[0] = tb[t]; op_s[0] = 1'b1;
      load(0);
      bus.req[0] = 1'b1;
      for (int k = 0; k < 10 && !eng_enable; k++) step();
      tests += 2;
      if (eng_datab !== tdb[t]) begin fails++;
        $display("FAIL sub_db[%0d] got %h want %h",
                 t, eng_datab, tdb[t]); end
      if (eng_dataa !== ta[t]) begin fails++;
        $display("FAIL sub_da[%0d] got %h want %h",
                 t, eng_dataa, ta[t]); end
      wait_resp(1, 20);
      tests++;
      if (rq_id.size() != 1) begin fails++;
        $display("FAIL sub_cnt[%0d] got %0d want 1",
                 t, rq_id.size());
      end else begin
        tests++;
        if (rq_data[0] !== expect_res(0)) begin fails++;
          $display("FAIL sub_data[%0d] got %h want %h",
                   t, rq_data[0], expect_res(0)); end
      end
      wait_idle();
    end
    tests++;
    op_s[0] = 1'b1; op_a[0] = 32'h40400000;
    op_b[0] = 32'h3F800000;
    if (expect_res(0) !== 32'h40000000) begin fails++;
      $display("FAIL sub_model got %h want 40000000",
               expect_res(0)); end
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_q();
    for (int i = 0; i < N; i++) begin
      op_a[i] = rnd_fp(); op_b[i] = rnd_fp();
      op_s[i] = 1'($urandom);
      load(i);
    end
    bus.req = '1;
    wait_resp(N, 80);
    tests++;
    if (rq_id.size() != N) begin fails++;
      $display("FAIL rr_cnt got %0d want %0d", rq_id.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        tests += 2;
        if (rq_id[i] != i) begin fails++;
          $display("FAIL rr_id[%0d] got %0d want %0d",
                   i, rq_id[i], i); end
        if (rq_data[i] !== expect_res(i)) begin fails++;
          $display("FAIL rr_data[%0d] got %h want %h",
                   i, rq_data[i], expect_res(i)); end
        if (i > 0) begin
          tests++;
          if (rq_cyc[i] - rq_cyc[i-1] != 4) begin fails++;
            $display("FAIL rr_gap[%0d] got %0d want 4",
                     i, rq_cyc[i] - rq_cyc[i-1]); end
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int t_iss;
    clear_q();
    hold_off = 1'b1;
    op_a[1] = rnd_fp(); op_b[1] = rnd_fp(); op_s[1] = 1'b0;
    load(1);
    bus.req[1] = 1'b1;
    for (int k = 0; k < 10 && !eng_enable; k++) step();
    t_iss = cyc;
    wait_resp(1, TO + 10);
    tests++;
    if (rq_id.size() != 1) begin fails++;
      $display("FAIL to_cnt got %0d want 1", rq_id.size());
    end else begin
      tests += 5;
      if (rq_err[0] !== 1'b1) begin fails++;
        $display("FAIL to_err got %b want 1", rq_err[0]); end
      if (rq_data[0] !== 32'd0) begin fails++;
        $display("FAIL to_data got %h want 0", rq_data[0]); end
      if (rq_id[0] != 1) begin fails++;
        $display("FAIL to_id got %0d want 1", rq_id[0]); end
      if (rq_cyc[0] - t_iss != TO) begin fails++;
        $display("FAIL to_lat got %0d want %0d",
                 rq_cyc[0] - t_iss, TO); end
      if (eng_enable !== 1'b0) begin fails++;
        $display("FAIL to_en got %b want 0", eng_enable); end
    end
    force_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (busy !== 1'b1) begin fails++;
        $display("FAIL to_drain[%0d] busy got %b want 1",
                 k, busy); end
    end
    force_done = 1'b0;
    hold_off   = 1'b0;
    step();
    tests += 2;
    if (busy !== 1'b0) begin fails++;
      $display("FAIL to_exit busy got %b want 0", busy); end
    if (rq_id.size() != 1) begin fails++;
      $display("FAIL to_extra got %0d want 1", rq_id.size()); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    op_a[3] = rnd_fp(); op_b[3] = rnd_fp(); op_s[3] = 1'b0;
    load(3);
    bus.req[3] = 1'b1;
    for (int k = 0; k < 10 && !eng_enable; k++) step();
    reset = 1'b1;
    bus.req[3] = 1'b0;
    step();
    reset = 1'b0;
    ref_ptr = N - 1;
    tests += 2;
    if (eng_enable !== 1'b0) begin fails++;
      $display("FAIL rm_en got %b want 0", eng_enable); end
    if (busy !== 1'b1) begin fails++;
      $display("FAIL rm_busy0 got %b want 1", busy); end
    step();
    tests++;
    if (busy !== 1'b1) begin fails++;
      $display("FAIL rm_busy1 got %b want 1", busy); end
    tests++;
    if (rq_id.size() != 0) begin fails++;
      $display("FAIL rm_noresp got %0d want 0", rq_id.size()); end
    for (int i = 0; i < N; i += 3) begin
      op_a[i] = rnd_fp(); op_b[i] = rnd_fp();
      op_s[i] = 1'($urandom);
      load(i);
    end
    bus.req = 4'b1001;
    wait_resp(2, 40);
    tests++;
    if (rq_id.size() != 2) begin fails++;
      $display("FAIL rm_cnt got %0d want 2", rq_id.size());
    end else begin
      tests += 3;
      if (rq_id[0] != 0 || rq_id[1] != 3) begin fails++;
        $display("FAIL rm_order got %0d,%0d want 0,3",
                 rq_id[0], rq_id[1]); end
      if (rq_data[0] !== expect_res(0)) begin fails++;
        $display("FAIL rm_data got %h want %h",
                 rq_data[0], expect_res(0)); end
      if (rq_err[0] !== 1'b0) begin fails++;
        $display("FAIL rm_err got %b want 0", rq_err[0]); end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int mask, exp_id[$], n;
    do_reset();
    for (int b = 0; b < 10; b++) begin
      wait_idle();
      clear_q();
      exp_id.delete();
      mask = int'($urandom_range(15, 1));
      for (int k = 1; k <= N; k++) begin
        n = (ref_ptr + k) % N;
        if (mask[n]) exp_id.push_back(n);
      end
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          op_a[i] = rnd_fp(); op_b[i] = rnd_fp();
          op_s[i] = 1'($urandom);
          load(i);
        end
      end
      bus.req = 4'(mask);
      wait_resp(exp_id.size(), 100);
      tests++;
      if (rq_id.size() != exp_id.size()) begin fails++;
        $display("FAIL b2b_cnt[%0d] got %0d want %0d",
                 b, rq_id.size(), exp_id.size());
        bus.req = '0;
      end else begin
        for (int j = 0; j < exp_id.size(); j++) begin
          tests += 3;
          if (rq_id[j] != exp_id[j]) begin fails++;
            $display("FAIL b2b_id[%0d.%0d] got %0d want %0d",
                     b, j, rq_id[j], exp_id[j]); end
          if (rq_data[j] !== expect_res(exp_id[j])) begin
            fails++;
            $display("FAIL b2b_data[%0d.%0d] got %h want %h",
                     b, j, rq_data[j], expect_res(exp_id[j]));
          end
          if (rq_err[j] !== 1'b0) begin fails++;
            $display("FAIL b2b_err[%0d.%0d] got %b want 0",
                     b, j, rq_err[j]); end
          if (j > 0) begin
            tests++;
            if (rq_cyc[j] - rq_cyc[j-1] != 4) begin fails++;
              $display("FAIL b2b_gap[%0d.%0d] got %0d want 4",
                       b, j, rq_cyc[j] - rq_cyc[j-1]); end
          end
        end
        ref_ptr = exp_id[exp_id.size()-1];
      end
    end
    wait_idle();
  endtask

  initial begin
    reset      = 1'b1;
    hold_off   = 1'b0;
    force_done = 1'b0;
    bus.req    = '0;
    bus.op_sub = '0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_s[i] = 1'b0;
    end
    ref_ptr = N - 1;
    test_reset();
    test_single_add();
    test_subtract();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
